// File: rtl/router_fifo_buf.sv
// Per-destination output FIFO of the 1x3 router: stores {header tag, byte}, one-cycle read latency,
// read-side packet tracking and soft-reset flush. Define ROUTER_FIFO_OCCUPANCY_EN to add the occupancy port.
module router_fifo_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int ADDR  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_out_valid,
    output logic             pkt_active,
    output logic             full,
`ifdef ROUTER_FIFO_OCCUPANCY_EN
    output logic [ADDR:0]    occupancy,
`endif
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] tag_q, tag_d;
    logic [ADDR:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-2:0] pkt_count_q, pkt_count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             valid_q, valid_d;

    logic             wr_acc_s, rd_acc_s;
    logic [ADDR-1:0]  waddr_s, raddr_s;
    logic [WIDTH-1:0] rd_byte_s;
    logic             rd_tag_s;

    assign waddr_s   = wr_ptr_q[ADDR-1:0];
    assign raddr_s   = rd_ptr_q[ADDR-1:0];
    assign rd_byte_s = mem_q[raddr_s];
    assign rd_tag_s  = tag_q[raddr_s];

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (waddr_s == raddr_s) && (wr_ptr_q[ADDR] != rd_ptr_q[ADDR]);
    assign wr_acc_s = write_enb && !full;
    assign rd_acc_s = read_enb && !empty;

    assign data_out       = data_out_q;
    assign data_out_valid = valid_q;
    assign pkt_active     = (pkt_count_q != {(WIDTH-1){1'b0}});
`ifdef ROUTER_FIFO_OCCUPANCY_EN
    assign occupancy      = wr_ptr_q - rd_ptr_q;
`endif

    // Next-state: soft_reset flushes and drops any same-cycle access; otherwise accept reads/writes.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        tag_d       = tag_q;
        pkt_count_d = pkt_count_q;
        data_out_d  = data_out_q;
        valid_d     = 1'b0;
        if (soft_reset) begin
            wr_ptr_d    = {(ADDR+1){1'b0}};
            rd_ptr_d    = {(ADDR+1){1'b0}};
            tag_d       = {DEPTH{1'b0}};
            pkt_count_d = {(WIDTH-1){1'b0}};
            data_out_d  = {WIDTH{1'b0}};
        end else begin
            if (wr_acc_s) begin
                wr_ptr_d       = wr_ptr_q + {{ADDR{1'b0}}, 1'b1};
                tag_d[waddr_s] = lfd_state;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_acc_s) begin
                rd_ptr_d   = rd_ptr_q + {{ADDR{1'b0}}, 1'b1};
                data_out_d = rd_byte_s;
                valid_d    = 1'b1;
                // A header reload abandons any unfinished count from a truncated packet.
                if (rd_tag_s) begin
                    pkt_count_d = {1'b0, rd_byte_s[WIDTH-1:2]} + {{(WIDTH-2){1'b0}}, 1'b1};
                end else if (pkt_count_q != {(WIDTH-1){1'b0}}) begin
                    pkt_count_d = pkt_count_q - {{(WIDTH-2){1'b0}}, 1'b1};
                end else begin
                    pkt_count_d = pkt_count_q;
                end
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= {(ADDR+1){1'b0}};
            rd_ptr_q    <= {(ADDR+1){1'b0}};
            tag_q       <= {DEPTH{1'b0}};
            pkt_count_q <= {(WIDTH-1){1'b0}};
            data_out_q  <= {WIDTH{1'b0}};
            valid_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            tag_q       <= tag_d;
            pkt_count_q <= pkt_count_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
        end
    end

    // Byte storage; contents are not cleared by either reset since the tags and pointers cover it.
    always_ff @(posedge clock) begin
        if (!reset && !soft_reset && wr_acc_s) begin
            mem_q[waddr_s] <= data_in;
        end
    end

endmodule

// File: tb/tb_router_fifo_buf.sv
// Self-checking bench for router_fifo_buf: queue-based reference model compared every cycle,
// directed test-plan scenarios with literal expectations, then randomized traffic.
module tb_router_fifo_buf;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int ADDR  = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             soft_reset = 1'b0;
    logic             write_enb = 1'b0;
    logic             read_enb = 1'b0;
    logic             lfd_state = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] data_out;
    logic             data_out_valid;
    logic             pkt_active;
    logic             full;
    logic             empty;
`ifdef ROUTER_FIFO_OCCUPANCY_EN
    logic [ADDR:0]    occupancy;
`endif

    router_fifo_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR)) dut (
        .clock(clock),
        .reset(reset),
        .soft_reset(soft_reset),
        .write_enb(write_enb),
        .read_enb(read_enb),
        .lfd_state(lfd_state),
        .data_in(data_in),
        .data_out(data_out),
        .data_out_valid(data_out_valid),
        .pkt_active(pkt_active),
        .full(full),
`ifdef ROUTER_FIFO_OCCUPANCY_EN
        .occupancy(occupancy),
`endif
        .empty(empty)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of {tag, byte} words plus the read-side packet count.
    logic [WIDTH:0]   q[$];
    logic [WIDTH-1:0] m_dout = '0;
    bit               m_valid = 1'b0;
    int               m_cnt = 0;
    bit               m_wa, m_ra;
    logic [WIDTH:0]   m_w;

    always @(posedge clock) begin
        if (reset || soft_reset) begin
            q.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_cnt   = 0;
        end else begin
            m_wa    = write_enb && (q.size() < DEPTH);
            m_ra    = read_enb && (q.size() > 0);
            m_valid = m_ra;
            if (m_ra) begin
                m_w    = q.pop_front();
                m_dout = m_w[WIDTH-1:0];
                if (m_w[WIDTH]) m_cnt = int'(m_w[WIDTH-1:2]) + 1;
                else if (m_cnt > 0) m_cnt = m_cnt - 1;
            end
            if (m_wa) q.push_back({lfd_state, data_in});
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("data_out", 32'(data_out), 32'(m_dout));
            chk("data_out_valid", 32'(data_out_valid), 32'(m_valid));
            chk("pkt_active", 32'(pkt_active), 32'(m_cnt != 0));
            chk("full", 32'(full), 32'(q.size() == DEPTH));
            chk("empty", 32'(empty), 32'(q.size() == 0));
`ifdef ROUTER_FIFO_OCCUPANCY_EN
            chk("occupancy", 32'(occupancy), 32'(q.size()));
`endif
        end
    end

    // One clock of stimulus: drive at a falling edge, return at the next falling edge.
    task automatic cyc(input bit rst, input bit srst, input bit we, input bit re,
                       input bit lfd, input logic [WIDTH-1:0] d);
        reset = rst; soft_reset = srst; write_enb = we; read_enb = re;
        lfd_state = lfd; data_in = d;
        @(negedge clock);
        reset = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0; lfd_state = 1'b0;
    endtask

    task automatic occ_chk(input string name, input int exp);
`ifdef ROUTER_FIFO_OCCUPANCY_EN
        chk(name, 32'(occupancy), 32'(exp));
`endif
    endtask

    logic [WIDTH-1:0] pkt1 [5];

    initial begin
        pkt1[0] = 8'h0D; pkt1[1] = 8'h11; pkt1[2] = 8'h22; pkt1[3] = 8'h33; pkt1[4] = 8'h3F;
        @(negedge clock);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk_en = 1'b1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_dout", 32'(data_out), 32'h0);
        chk("rst_valid", 32'(data_out_valid), 32'd0);
        chk("rst_pkt_active", 32'(pkt_active), 32'd0);
        occ_chk("rst_occ", 0);

        // Packet 0D,11,22,33,3F then read it back.
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, (i == 0), pkt1[i]);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            chk("p1_dout", 32'(data_out), 32'(pkt1[i]));
            chk("p1_valid", 32'(data_out_valid), 32'd1);
            chk("p1_active", 32'(pkt_active), 32'(i != 4));
        end
        chk("p1_cnt_model", 32'(m_cnt), 32'd0);
        chk("p1_empty", 32'(empty), 32'd1);

        // Fill to 16, ignored 17th write, drain 16, ignored 17th read.
        for (int i = 1; i <= 16; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'(i));
        chk("fill_full", 32'(full), 32'd1);
        occ_chk("fill_occ", 16);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hAA);
        chk("fill_full17", 32'(full), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            chk("drain_dout", 32'(data_out), 32'(i));
        end
        occ_chk("drain_occ", 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("drain17_valid", 32'(data_out_valid), 32'd0);
        chk("drain17_hold", 32'(data_out), 32'd16);

        // 15 words then 10 cycles of simultaneous read/write across the wrap.
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'(8'h80 + i));
            chk("rw_dout", 32'(data_out), 32'(8'h40 + i));
            occ_chk("rw_occ", 15);
        end
        chk("rw_full", 32'(full), 32'd0);
        while (!empty) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        // Simultaneous write/read on empty: write only.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A);
        chk("we_re_empty_valid", 32'(data_out_valid), 32'd0);
        chk("we_re_empty_empty", 32'(empty), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("we_re_empty_dout", 32'(data_out), 32'h5A);

        // 6-byte packet (header 0x10 -> count 5), read 2, soft_reset with a write of FF.
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, (i == 0), (i == 0) ? 8'h10 : 8'(8'hC0 + i));
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("sr_pre_active", 32'(pkt_active), 32'd1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
        chk("sr_empty", 32'(empty), 32'd1);
        chk("sr_active", 32'(pkt_active), 32'd0);
        chk("sr_dout", 32'(data_out), 32'h0);
        occ_chk("sr_occ", 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h08);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("sr_fresh_dout", 32'(data_out), 32'h08);
        chk("sr_fresh_cnt_model", 32'(m_cnt), 32'd3);
        chk("sr_fresh_empty", 32'(empty), 32'd1);

        // Randomized traffic, including rare resets and soft resets.
        for (int i = 0; i < 4000; i++) begin
            int mode;
            bit rs, sr, we, re;
            mode = i / 500;
            rs = ($urandom_range(0, 699) == 0);
            sr = ($urandom_range(0, 249) == 0);
            we = ($urandom_range(0, 9) < ((mode % 3 == 0) ? 8 : (mode % 3 == 1) ? 3 : 5));
            re = ($urandom_range(0, 9) < ((mode % 3 == 0) ? 3 : (mode % 3 == 1) ? 8 : 5));
            cyc(rs, sr, we, re, ($urandom_range(0, 5) == 0), 8'($urandom_range(0, 255)));
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        occ_chk("end_rst_occ", 0);
        chk("end_rst_empty", 32'(empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/router_fifo_buf.md
Name: router_fifo_buf

Overview:
- Per-destination output FIFO of the 1x3 router, directly downstream of the register stage; one instance per output port.
- Stores the byte stream from the register stage (header, payload, parity) and tags each header word with the lfd_state flag.
- Presents bytes to the destination read side with one-cycle read latency.
- Tracks the packet boundary on the read side from the header length field, and supports a soft reset that flushes the FIFO when the destination times out.

Parameters:
- WIDTH, 8, data byte width; header length field is data[WIDTH-1:2].
- DEPTH, 16, number of storage words; must be a power of 2.
- ADDR, 4, pointer width; log2(DEPTH).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- soft_reset  in  1  synchronous flush from sync/timeout logic; active-high.
- write_enb  in  1  write request.
- read_enb  in  1  read request from destination.
- lfd_state  in  1  current write carries the header byte; stored as tag bit.
- data_in  in  WIDTH  byte from register stage.
- data_out  out  WIDTH  registered read data.
- data_out_valid  out  1  data_out updated by a read accepted last cycle.
- pkt_active  out  1  read-side packet in progress (count != 0).
- full  out  1  DEPTH words stored.
- empty  out  1  zero words stored.

Behaviour:
- Storage: DEPTH x (WIDTH+1) array holding {tag, byte}.
- Pointers: wr_ptr and rd_ptr, ADDR+1 bits each; the extra MSB is the wrap bit.
- Flags are combinational from the pointers:
  - empty = (wr_ptr == rd_ptr).
  - full = (addresses equal AND MSBs differ).
- Write accept: write_enb && !full. Stores {lfd_state, data_in} at wr_ptr[ADDR-1:0]; wr_ptr increments.
- Write when full: ignored. No pointer change, no storage change. This holds even if read_enb is also high that cycle.
- Read accept: read_enb && !empty.
  - Next cycle: data_out = stored byte, data_out_valid = 1.
  - rd_ptr increments.
- Read when empty: ignored. data_out holds its value; data_out_valid = 0 next cycle.
- Simultaneous accepted read and write: both occur, occupancy unchanged.
  - Write and read when empty: write only.
  - Write and read when full: read only.
- Pointer wrap: addresses wrap DEPTH-1 -> 0 and the wrap bit toggles. Wrap is invisible externally except through full/empty.
- Packet counter pkt_count (WIDTH-1 bits), updated only on an accepted read:
  - Tagged word read: pkt_count <= byte[WIDTH-1:2] + 1 (payload + parity). This reloads even if the count is nonzero, i.e. a truncated previous packet is abandoned.
  - Untagged word read with pkt_count != 0: decrement by 1.
  - Untagged word read with pkt_count == 0: count stays 0; the byte is still output.
- pkt_active = (pkt_count != 0), combinational.
- reset (highest priority):
  - wr_ptr = rd_ptr = 0, pkt_count = 0, all tag bits = 0.
  - Outputs: data_out = 0, data_out_valid = 0, full = 0, empty = 1, pkt_active = 0.
- soft_reset (below reset, above read/write): same effect as reset, including data_out = 0. Any write or read in the same cycle is dropped. Storage byte contents need not be cleared.
- Reset or soft_reset mid-packet: a partially written or partially read packet is discarded entirely. There is no residual tag state.

Optional Feature:
- Macro: ROUTER_FIFO_OCCUPANCY_EN.
- Defined:
  - Adds output port occupancy [ADDR:0] = wr_ptr - rd_ptr (modulo 2^(ADDR+1)), range 0..DEPTH, combinational.
  - Reads 0 after reset or soft_reset.
- Undefined: the port is absent; all other behaviour is identical.

Test Plan:
- Reset, then write header 8'h0D with lfd_state=1, followed by payload 8'h11, 8'h22, 8'h33 and parity 8'h3F. Then read 5 times:
  - data_out sequence 0D,11,22,33,3F, each valid one cycle after its read_enb.
  - pkt_count loads 4 on the header read (0x0D[7:2]=3, +1).
  - pkt_active drops after the parity read; empty=1 at end.
- Write 16 bytes with no reads:
  - full=1 after the 16th write; a 17th write of 8'hAA is ignored.
  - Reading 16 returns bytes 1..16 in order; the 17th read gives data_out_valid=0.
- Fill 15 words, then assert write_enb and read_enb together for 10 cycles:
  - Occupancy stays 15; pointers wrap past 15->0.
  - Output order is preserved across the wrap.
- Empty FIFO, write_enb and read_enb same cycle with 8'h5A:
  - The write is stored, the read is ignored (data_out_valid=0).
  - Next-cycle read returns 8'h5A.
- Write a 6-byte packet, read 2 bytes, pulse soft_reset together with a write of 8'hFF:
  - empty=1, pkt_active=0, data_out=0; the 8'hFF is not stored.
  - A following header write/read starts a fresh count.
- With ROUTER_FIFO_OCCUPANCY_EN defined:
  - occupancy tracks 0->16->0 through the full/drain sequence.
  - occupancy reads 0 after both reset and soft_reset.
